xadc_drp_scanner: RTL and testbench



---
 rtl/xadc_drp_scanner.sv | 113 +++++++++++
 tb/tb_xadc_drp_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_scanner.sv
// DRP read master for the XADC: on each end-of-conversion it reads the current
// channel, averages 2^AVG_LOG2 readings and publishes one 12-bit result per channel.
module xadc_drp_scanner #(
   parameter int unsigned          NUM_CH   = 4,
   parameter logic [7*NUM_CH-1:0]  CH_ADDRS = {7'h19, 7'h18, 7'h10, 7'h11},
   parameter int unsigned          AVG_LOG2 = 2,
   parameter int unsigned          TIMEOUT  = 255
) (
   input  logic                   CLK100MHZ,
   input  logic                   RST,
   input  logic                   eoc,
   input  logic                   drdy,
   input  logic [15:0]            do_in,
   output logic [6:0]             daddr,
   output logic                   den,
   output logic                   dwe,
   output logic [12*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]      ch_valid,
   output logic                   timeout_err
);

   localparam int unsigned AW  = 12 + AVG_LOG2;
   localparam int unsigned CW  = AVG_LOG2 + 1;
   localparam int unsigned CIW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned TW  = 8;
   localparam logic [CW-1:0] LAST_CNT  = CW'((1 << AVG_LOG2) - 1);
   localparam logic [CIW-1:0] LAST_CH  = CIW'(NUM_CH - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state;
   logic [CIW-1:0]   ch_idx;
   logic [AW-1:0]    acc;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    tcnt;

   logic [11:0]      sample_c;
   logic [AW-1:0]    sum_c;
   logic [11:0]      avg_c;
   logic [6:0]       cur_addr_c;
   logic             unused_lsbs;

   assign dwe         = 1'b0;
   assign sample_c    = do_in[15:4];
   assign unused_lsbs = ^do_in[3:0];
   assign sum_c       = acc + AW'(sample_c);
   assign avg_c       = 12'(sum_c >> AVG_LOG2);

   // DRP address of the channel currently being scanned
   always_comb begin
      cur_addr_c = CH_ADDRS[6:0];
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_idx == CIW'(i)) cur_addr_c = CH_ADDRS[7*i +: 7];
      end
   end

   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         ch_idx      <= '0;
         daddr       <= CH_ADDRS[6:0];
         den         <= 1'b0;
         ch_data     <= '0;
         ch_valid    <= '0;
         timeout_err <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         tcnt        <= '0;
      end else begin
         den      <= 1'b0;
         ch_valid <= '0;
         case (state)
            IDLE: begin
               if (eoc) begin
                  state <= REQ;
                  den   <= 1'b1;
                  daddr <= cur_addr_c;
                  tcnt  <= '0;
               end
            end
            REQ: state <= WAIT;
            WAIT: begin
               // drdy takes priority over a timeout expiring in the same cycle
               if (drdy) begin
                  state <= IDLE;
                  if (cnt == LAST_CNT) begin
                     for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_idx == CIW'(i)) begin
                           ch_data[12*i +: 12] <= avg_c;
                           ch_valid[i]         <= 1'b1;
                        end
                     end
                     acc    <= '0;
                     cnt    <= '0;
                     ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
                  end else begin
                     acc <= sum_c;
                     cnt <= cnt + 1'b1;
                  end
               end else if (tcnt == LAST_TICK) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Self-checking bench for xadc_drp_scanner: a transaction-level model predicts
// every output each cycle; directed scenarios add literal end-point checks.
module tb_xadc_drp_scanner;

   logic        clk = 1'b0;
   logic        RST = 1'b0;
   logic        eoc = 1'b0;
   logic        drdy = 1'b0;
   logic [15:0] do_in = 16'h0;
   logic [6:0]  daddr;
   logic        den;
   logic        dwe;
   logic [47:0] ch_data;
   logic [3:0]  ch_valid;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;

   xadc_drp_scanner dut (
      .CLK100MHZ  (clk),
      .RST        (RST),
      .eoc        (eoc),
      .drdy       (drdy),
      .do_in      (do_in),
      .daddr      (daddr),
      .den        (den),
      .dwe        (dwe),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding read at a time, samples kept in a queue
   logic [6:0]  addr_tab [4] = '{7'h11, 7'h10, 7'h18, 7'h19};
   logic [11:0] exp_data [4];
   logic [3:0]  exp_valid;
   logic        exp_den;
   logic [6:0]  exp_addr;
   logic        exp_err;
   bit          open_rd;
   int          age;
   int          exp_ch;
   int          samples [$];

   always @(posedge clk or posedge RST) begin
      if (RST) begin
         foreach (exp_data[i]) exp_data[i] = 12'h0;
         exp_valid = 4'h0;
         exp_den   = 1'b0;
         exp_addr  = 7'h11;
         exp_err   = 1'b0;
         open_rd   = 1'b0;
         age       = 0;
         exp_ch    = 0;
         samples.delete();
      end else begin
         exp_valid = 4'h0;
         if (exp_den) begin
            exp_den = 1'b0;
            open_rd = 1'b1;
            age     = 0;
         end else if (open_rd) begin
            if (drdy) begin
               int sum;
               samples.push_back(int'(do_in[15:4]));
               if (samples.size() == 4) begin
                  sum = 0;
                  foreach (samples[k]) sum += samples[k];
                  exp_data[exp_ch] = 12'(sum / 4);
                  exp_valid        = 4'(1 << exp_ch);
                  exp_ch           = (exp_ch + 1) % 4;
                  samples.delete();
               end
               open_rd = 1'b0;
            end else begin
               age++;
               if (age == 255) begin
                  exp_err = 1'b1;
                  open_rd = 1'b0;
               end
            end
         end else if (eoc) begin
            exp_den  = 1'b1;
            exp_addr = addr_tab[exp_ch];
         end
      end
   end

   // Per-cycle compare plus logging of issued addresses and valid strobes
   logic [6:0] den_q [$];
   logic [3:0] vq [$];

   always @(posedge clk) begin
      #2;
      chk("den", 64'(den), 64'(exp_den));
      chk("ch_valid", 64'(ch_valid), 64'(exp_valid));
      chk("ch_data", 64'(ch_data), 64'({exp_data[3], exp_data[2], exp_data[1], exp_data[0]}));
      chk("timeout_err", 64'(timeout_err), 64'(exp_err));
      chk("dwe", 64'(dwe), 64'(1'b0));
      if (exp_den) chk("daddr", 64'(daddr), 64'(exp_addr));
      if (den) den_q.push_back(daddr);
      if (ch_valid != 4'h0) vq.push_back(ch_valid);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk) RST = 1'b1;
      repeat (3) begin
         @(negedge clk) begin eoc = ~eoc; drdy = ~drdy; end
      end
      @(negedge clk) begin eoc = 1'b0; drdy = 1'b0; RST = 1'b0; end
      den_q.delete();
      vq.delete();
      idle(2);
   endtask

   task automatic pulse_eoc();
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) eoc = 1'b0;
   endtask

   task automatic round(input logic [15:0] d);
      pulse_eoc();
      @(negedge clk) begin drdy = 1'b1; do_in = d; end
      @(negedge clk) drdy = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] grp [4];
      int nvq;
      grp = '{7'h11, 7'h10, 7'h18, 7'h19};

      // Reset held while inputs toggle
      @(negedge clk) RST = 1'b1;
      repeat (4) begin
         @(negedge clk) begin eoc = ~eoc; drdy = ~drdy; do_in = 16'hFFF0; end
         @(posedge clk); #2;
         chk("rst_den", 64'(den), 64'(0));
         chk("rst_ch_valid", 64'(ch_valid), 64'(0));
         chk("rst_ch_data", 64'(ch_data), 64'(0));
         chk("rst_daddr", 64'(daddr), 64'(7'h11));
         chk("rst_timeout_err", 64'(timeout_err), 64'(0));
      end
      @(negedge clk) begin eoc = 1'b0; drdy = 1'b0; RST = 1'b0; end
      den_q.delete();
      vq.delete();
      idle(2);

      // Averaging on channel 0
      round(16'h1000);
      round(16'h2000);
      round(16'h3000);
      round(16'h4000);
      chk("avg_ch0", 64'(ch_data[11:0]), 64'(12'h280));
      chk("avg_valid_count", 64'(vq.size()), 64'(1));
      if (vq.size() > 0) chk("avg_valid_bits", 64'(vq[0]), 64'(4'b0001));
      chk("avg_den_count", 64'(den_q.size()), 64'(4));

      // Rotation over all channels from a fresh reset
      do_reset();
      repeat (16) round(16'hFFF0);
      pulse_eoc();
      idle(2);
      chk("rot_den_count", 64'(den_q.size()), 64'(17));
      if (den_q.size() == 17) begin
         for (int k = 0; k < 16; k++) chk("rot_daddr", 64'(den_q[k]), 64'(grp[k/4]));
         chk("rot_daddr_wrap", 64'(den_q[16]), 64'(7'h11));
      end
      chk("rot_data", 64'(ch_data), 64'(48'hFFF_FFF_FFF_FFF));
      chk("rot_valid_count", 64'(vq.size()), 64'(4));
      if (vq.size() == 4) begin
         chk("rot_valid0", 64'(vq[0]), 64'(4'b0001));
         chk("rot_valid1", 64'(vq[1]), 64'(4'b0010));
         chk("rot_valid2", 64'(vq[2]), 64'(4'b0100));
         chk("rot_valid3", 64'(vq[3]), 64'(4'b1000));
      end

      // Timeout: the read issued above never gets drdy
      idle(200);
      chk("to_not_yet", 64'(timeout_err), 64'(0));
      idle(100);
      chk("to_err", 64'(timeout_err), 64'(1));
      chk("to_daddr", 64'(daddr), 64'(7'h11));
      nvq = vq.size();
      round(16'h8000);
      chk("to_no_publish", 64'(vq.size()), 64'(nvq));
      chk("to_ch0_kept", 64'(ch_data[11:0]), 64'(12'hFFF));
      repeat (3) round(16'h8000);
      chk("to_ch0_avg", 64'(ch_data[11:0]), 64'(12'h800));
      chk("to_err_sticky", 64'(timeout_err), 64'(1));

      // Ignored events: eoc during REQ/WAIT, drdy in IDLE and REQ
      do_reset();
      chk("ign_err_cleared", 64'(timeout_err), 64'(0));
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) begin eoc = 1'b1; drdy = 1'b1; do_in = 16'h4000; end
      @(negedge clk) begin eoc = 1'b0; drdy = 1'b0; end
      idle(2);
      @(negedge clk) begin drdy = 1'b1; do_in = 16'hFFF0; end
      @(negedge clk) drdy = 1'b0;
      idle(2);
      @(negedge clk) eoc = 1'b1;
      @(negedge clk) begin eoc = 1'b0; drdy = 1'b1; do_in = 16'hFFF0; end
      @(negedge clk) begin drdy = 1'b1; do_in = 16'h4000; end
      @(negedge clk) drdy = 1'b0;
      idle(2);
      round(16'h4000);
      round(16'h4000);
      chk("ign_den_count", 64'(den_q.size()), 64'(4));
      chk("ign_ch0", 64'(ch_data[11:0]), 64'(12'h400));
      chk("ign_valid_count", 64'(vq.size()), 64'(1));

      // Reset in the middle of an outstanding read
      do_reset();
      pulse_eoc();
      idle(2);
      @(negedge clk) RST = 1'b1;
      @(negedge clk) RST = 1'b0;
      @(negedge clk) begin drdy = 1'b1; do_in = 16'hFFF0; end
      @(negedge clk) drdy = 1'b0;
      idle(3);
      chk("mid_no_valid", 64'(vq.size()), 64'(0));
      chk("mid_data", 64'(ch_data), 64'(0));
      den_q.delete();
      pulse_eoc();
      idle(2);
      chk("mid_den_count", 64'(den_q.size()), 64'(1));
      if (den_q.size() == 1) chk("mid_ch_idx0", 64'(den_q[0]), 64'(7'h11));
      idle(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
